// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: stretches bench reset into core reset and ends a run on tohost store, PC self-loop hang or cycle budget
module sim_run_ctrl #(
  parameter int XLEN = 32,
  parameter int CNT_W = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES = 100,
  parameter int HANG_LIMIT = 16,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             core_rst,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             hang,
  output logic [XLEN-1:0]  exit_code
);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int HW = $clog2(HANG_LIMIT + 1);
  typedef enum logic [1:0] {RESET, RUN, DONE} state_t;
  state_t state;
  logic [RW-1:0] rcnt;
  logic [HW-1:0] hang_cnt;
  logic [XLEN-1:0] last_pc;
  logic last_pc_valid;
  logic same_pc, hang_ev, tohost_ev, timeout_ev;
  logic [CNT_W-1:0] cyc_nx, ins_nx;
  always_comb begin
    same_pc = last_pc_valid && wb_pc == last_pc;
    hang_ev = wb_valid && same_pc && hang_cnt == HW'(HANG_LIMIT - 1);
    tohost_ev = st_valid && st_addr == TOHOST_ADDR;
    timeout_ev = 64'(cycle_cnt) == 64'(MAX_CYCLES - 1);
    cyc_nx = &cycle_cnt ? cycle_cnt : cycle_cnt + CNT_W'(1);
    ins_nx = (wb_valid && !(&instret_cnt)) ? instret_cnt + CNT_W'(1) : instret_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET;
      rcnt <= '0;
      core_rst <= 1'b1;
      cycle_cnt <= '0;
      instret_cnt <= '0;
      hang_cnt <= '0;
      exit_code <= '0;
      done <= 1'b0;
      pass <= 1'b0;
      timeout <= 1'b0;
      hang <= 1'b0;
      last_pc <= '0;
      last_pc_valid <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          rcnt <= rcnt + RW'(1);
          if (rcnt == RW'(RESET_CYCLES - 1)) begin
            state <= RUN;
            core_rst <= 1'b0;
          end
        end
        RUN: begin
          cycle_cnt <= cyc_nx;
          instret_cnt <= ins_nx;
          if (wb_valid) begin
            if (same_pc) hang_cnt <= hang_cnt + HW'(1);
            else begin
              last_pc <= wb_pc;
              last_pc_valid <= 1'b1;
              hang_cnt <= HW'(1);
            end
          end
          if (tohost_ev) begin
            state <= DONE;
            done <= 1'b1;
            exit_code <= st_data;
            pass <= st_data == XLEN'(1);
          end else if (hang_ev) begin
            state <= DONE;
            done <= 1'b1;
            hang <= 1'b1;
            pass <= 1'b0;
          end else if (timeout_ev) begin
            state <= DONE;
            done <= 1'b1;
            timeout <= 1'b1;
            pass <= 1'b0;
          end
        end
        DONE: state <= DONE;
        default: state <= RESET;
      endcase
    end
  end
endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Parametrised run controller and end-of-test monitor for the RISC-V pipeline harness. It sits between the bench and the `top` core.
- Stretches the bench reset into a core reset of configurable length and counts cycles and retired instructions.
- Ends a run on whichever comes first: a tohost store, a PC self-loop hang, or a cycle budget timeout.
- Reports sticky done, pass, timeout, hang and exit-code status, so benches stop using fixed-delay finishes.

Parameters:
- XLEN, 32, data and address width of the monitored buses
- CNT_W, 32, width of the cycle and instret counters
- RESET_CYCLES, 2, cycles core_rst is held after rst deasserts; must be >= 1
- MAX_CYCLES, 100, cycle budget spent in RUN before timeout; must be >= 1
- HANG_LIMIT, 16, consecutive retirements of one PC that count as a hang; must be >= 2
- TOHOST_ADDR, 32'h0000_1000, store address that signals end of test

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- core_rst  out  1  reset to the core, active-high
- wb_valid  in  1  one instruction retired this cycle
- wb_pc  in  XLEN  PC of the retiring instruction
- st_valid  in  1  data-memory store this cycle
- st_addr  in  XLEN  store address
- st_data  in  XLEN  store data
- cycle_cnt  out  CNT_W  cycles spent in RUN
- instret_cnt  out  CNT_W  retirements seen in RUN
- done  out  1  run finished (sticky)
- pass  out  1  finished with exit_code == 1
- timeout  out  1  finished by cycle budget
- hang  out  1  finished by PC self-loop
- exit_code  out  XLEN  st_data captured from the tohost store

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- rst high at any clock edge, including mid-run or in DONE, produces:
  - state=RESET and rcnt=0
  - core_rst=1
  - cycle_cnt, instret_cnt, hang_cnt and exit_code cleared to 0
  - done, pass, timeout and hang cleared to 0
  - last_pc_valid=0
- FSM states are RESET, RUN and DONE.
- RESET:
  - core_rst=1.
  - rcnt increments on each edge with rst low.
  - When rcnt==RESET_CYCLES-1, go to RUN. core_rst therefore falls exactly RESET_CYCLES edges after the first edge with rst low.
- RUN, counters:
  - cycle_cnt increments every edge.
  - instret_cnt increments on each edge where wb_valid=1.
  - Both counters saturate at all-ones.
- RUN, hang tracking:
  - wb_valid with (!last_pc_valid or wb_pc!=last_pc): last_pc<=wb_pc, last_pc_valid<=1, hang_cnt<=1.
  - wb_valid with wb_pc==last_pc: hang_cnt increments.
  - hang_ev is true when wb_valid, wb_pc==last_pc and hang_cnt==HANG_LIMIT-1. That event is the HANG_LIMIT-th consecutive retirement of the same PC.
  - wb_valid=0 leaves last_pc and hang_cnt unchanged; stall bubbles do not reset them.
- RUN, other events:
  - tohost_ev = st_valid && st_addr==TOHOST_ADDR.
  - timeout_ev = cycle_cnt==MAX_CYCLES-1.
- RUN, termination:
  - On any event, go to DONE at that edge; done=1 is visible the cycle after the event.
  - Priority when events coincide: tohost > hang > timeout. Exactly one of the following is set:
  - tohost: exit_code<=st_data, pass<=(st_data==1).
  - hang: hang<=1, pass<=0.
  - timeout: timeout<=1, pass<=0.
  - The counters include the terminating edge's increments.
- DONE:
  - core_rst stays 0.
  - Counters and status are frozen.
  - Later stores, including further tohost stores, and retirements are ignored until rst.
- A store to any other address is ignored. A tohost store with st_data!=1 gives done=1, pass=0 and exit_code=st_data (the riscv-tests fail code).
- Inputs in RESET state are ignored.

Test Plan:
1. Reset stretch: rst high for 2 cycles, then low; RESET_CYCLES=3 -> core_rst falls exactly 3 edges after the first low-rst edge; cycle_cnt=0 throughout RESET.
2. Pass via tohost: retire 5 distinct PCs (0x00, 0x04, 0x08, 0x0C, 0x10), then a store of 1 to 0x1000 -> next cycle done=1, pass=1, exit_code=1, instret_cnt=5; outputs unchanged 20 cycles later.
3. Fail plus coincident events: tohost store of 0x7 in the same cycle as the 16th retirement of PC 0x40 -> done=1, pass=0, exit_code=7, hang=0 (tohost priority).
4. Hang: retire PC 0x20 every other cycle with bubbles in between, HANG_LIMIT=16 -> hang=1 the cycle after the 16th retirement, instret_cnt=16, timeout=0.
5. Timeout: MAX_CYCLES=100, no stores, distinct PCs only -> done=1 and timeout=1 the cycle after cycle_cnt reaches 99; final cycle_cnt=100.
6. Reset mid-run and saturation: pulse rst at RUN cycle 40 -> all outputs return to reset values and the run restarts; with CNT_W=4 and MAX_CYCLES=40, cycle_cnt saturates at 15 without wrapping.
